nabp_processing_element: RTL and testbench
==========================================

NABP_PROCESSING_ELEMENT -- requirements
Module: nabp_processing_element

Interface
REQ-001 SHALL have parameter pDataLength, default 12, width of one signed filtered tap value.
REQ-002 SHALL have parameter pAccLength, default 20, width of one signed accumulator word.
REQ-003 SHALL have parameter pImageSize, default 256, number of accumulators (pixels per line).
REQ-004 SHALL have parameter pAddrLength, default 8, equal to ceil(log2(pImageSize)).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port pe_en, input, 1, tap valid from the processing data path; low cycles are stalls.
REQ-008 SHALL have port pe_tap, input, pDataLength, signed tap value for the current scan position.
REQ-009 SHALL have port pe_scan_dir, input, 1, 0 = ascending scan from 0, 1 = descending scan from pImageSize-1.
REQ-010 SHALL have port clear, input, 1, single-cycle request to zero all accumulators.
REQ-011 SHALL have port flush, input, 1, single-cycle request to stream all accumulators out.
REQ-012 SHALL have port pe_busy, output, 1, high in CLEAR and DRAIN; upstream holds pe_en low while it is high.
REQ-013 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_addr (output, pAddrLength), out_val (output, pAccLength) and out_last (output, 1), forming the drain stream.
REQ-014 SHALL have ports line_done (output, 1), a one-cycle pulse after the last tap of a line, and err (output, 1), a sticky protocol-error flag.
REQ-015 SHALL have port sat (output, 1), a sticky flag set on any saturated add.

Function
REQ-016 SHALL implement states IDLE, CLEAR, ACCUM and DRAIN.
REQ-017 From IDLE: flush goes to DRAIN; otherwise clear goes to CLEAR; otherwise pe_en=1 goes to ACCUM. flush takes priority over clear, and clear over pe_en; the losing requests are dropped and err is set.
REQ-018 On entry to ACCUM, pe_scan_dir SHALL be latched for the whole line; the pointer starts at 0 (dir 0) or pImageSize-1 (dir 1), and the entry tap is accepted in the same cycle.
REQ-019 In ACCUM, each pe_en=1 cycle SHALL do acc[ptr] <= sat(acc[ptr] + sign-extended pe_tap) and then step ptr by ±1; pe_en=0 SHALL hold ptr with no write.
REQ-020 Accumulate SHALL be a two-stage read-modify-write: an accepted tap appears in its accumulator 2 cycles later. Consecutive pointers never alias, so no forwarding is required.
REQ-021 Saturation SHALL clamp to +(2^(pAccLength-1)-1) or -(2^(pAccLength-1)) and set sat.
REQ-022 After the tap at the terminal pointer (pImageSize-1 ascending, 0 descending), the block SHALL pulse line_done and return to IDLE once the final write completes.
REQ-023 In ACCUM, clear or flush SHALL be ignored and set err.
REQ-024 CLEAR SHALL write zero to addresses 0..pImageSize-1, one per cycle, then return to IDLE.
REQ-025 DRAIN SHALL present addresses 0..pImageSize-1 in ascending order using synchronous-read RAM plus a skid register, so it sustains one word per cycle while out_ready=1.
REQ-026 While out_valid=1 and out_ready=0, out_addr, out_val and out_last SHALL hold stable.
REQ-027 out_last SHALL be high with address pImageSize-1; its acceptance returns the block to IDLE. Drain is non-destructive.
REQ-028 pe_en=1 while pe_busy=1 SHALL set err, drop the tap, and leave the current operation unaffected.

Reset
REQ-029 reset_n=0 SHALL force IDLE and drive pe_busy, out_valid, out_last, line_done, err and sat to 0, and out_addr and out_val to 0.
REQ-030 Reset SHALL NOT zero the accumulator RAM (a clear request is required); reset mid-operation abandons it with no further writes.

Structure
REQ-031 State encoding, parameter defaults and the saturating-add width rule SHALL live in the shared nabp package/defines beside kFilteredDataLength.
REQ-032 The accumulator storage SHALL be one sub-module, nabp_pe_line_ram: single-clock, 1 read port plus 1 write port, synchronous read.

Verification
REQ-033 clear, then a dir-0 line of pe_tap=5, then flush with out_ready=1 -> 256 words, addr 0..255, all value 5, out_last at 255.
REQ-034 dir-1 line with pe_tap=addr-index, with pe_en low every third cycle -> after flush, acc[k]=k; line_done pulses once.
REQ-035 Accumulate +100000 repeatedly at pAccLength=20 -> value clamps to 524287 and sat=1.
REQ-036 Drain with out_ready toggling 1,0,0,1 -> no duplicate or skipped addresses, and outputs stay stable while stalled.
REQ-037 clear and flush in the same IDLE cycle, or pe_en during DRAIN -> DRAIN proceeds, err=1, buffer unchanged.
REQ-038 reset_n low mid-ACCUM at ptr 100 -> IDLE next cycle with all outputs 0; a subsequent line is accepted normally.

Source files
------------

// File: rtl/nabp_pkg.sv
// Shared constants for the NABP processing element: default widths,
// FSM state encoding and the guard-bit rule for the saturating adder.
package nabp_pkg;

  // Width of one signed filtered tap produced by the filter stage.
  localparam int kFilteredDataLength = 12;

  // Default accumulator geometry.
  localparam int kAccLength  = 20;
  localparam int kImageSize  = 256;
  localparam int kAddrLength = 8;

  // The accumulate sum is computed kSatGuardBits wider than the accumulator;
  // a guard bit that disagrees with the accumulator sign bit means overflow.
  localparam int kSatGuardBits = 1;

  // FSM state encoding.
  typedef logic [1:0] nabp_state_t;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_ACCUM = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/nabp_pe_line_ram.sv
// Accumulator line store: one write port, one synchronous read port, one
// clock. Contents are never reset; the PE zeroes them with a CLEAR pass.
module nabp_pe_line_ram
  import nabp_pkg::*;
#(
  parameter int pWidth      = kAccLength,
  parameter int pDepth      = kImageSize,
  parameter int pAddrLength = kAddrLength
) (
  input  logic                   clk,
  input  logic                   we_i,
  input  logic [pAddrLength-1:0] waddr_i,
  input  logic [pWidth-1:0]      wdata_i,
  input  logic                   re_i,
  input  logic [pAddrLength-1:0] raddr_i,
  output logic [pWidth-1:0]      rdata_o
);

  logic [pWidth-1:0] mem_q [pDepth];

  // Write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Synchronous read port; data holds between reads.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/nabp_processing_element.sv
// NABP processing element: a line of saturating accumulators that are
// cleared, accumulated along an ascending or descending scan, and drained
// through a ready/valid stream backed by a synchronous-read RAM plus skid.
module nabp_processing_element
  import nabp_pkg::*;
#(
  parameter int pDataLength = kFilteredDataLength,
  parameter int pAccLength  = kAccLength,
  parameter int pImageSize  = kImageSize,
  parameter int pAddrLength = kAddrLength
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pe_en,
  input  logic [pDataLength-1:0] pe_tap,
  input  logic                   pe_scan_dir,
  input  logic                   clear,
  input  logic                   flush,
  output logic                   pe_busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [pAddrLength-1:0] out_addr,
  output logic [pAccLength-1:0]  out_val,
  output logic                   out_last,
  output logic                   line_done,
  output logic                   err,
  output logic                   sat
);

  localparam int kSumW = pAccLength + kSatGuardBits;

  localparam logic [pAddrLength-1:0] kZeroAddr = '0;
  localparam logic [pAddrLength-1:0] kOneAddr  = pAddrLength'(1);
  localparam logic [pAddrLength-1:0] kLastAddr = pAddrLength'(pImageSize - 1);

  localparam logic [pAccLength-1:0] kAccMax = {1'b0, {(pAccLength-1){1'b1}}};
  localparam logic [pAccLength-1:0] kAccMin = {1'b1, {(pAccLength-1){1'b0}}};

  // Control state.
  nabp_state_t            state_q, state_d;
  logic                   dir_q, dir_d;
  logic [pAddrLength-1:0] ptr_q, ptr_d;
  logic                   term_seen_q, term_seen_d;
  logic [pAddrLength-1:0] clr_addr_q, clr_addr_d;
  logic                   busy_q, busy_d;
  logic                   line_done_q, line_done_d;
  logic                   err_q, err_d;
  logic                   sat_q, sat_d;
  logic                   err_set_s;

  // Read-modify-write second stage.
  logic                   s1_valid_q, s1_valid_d;
  logic [pAddrLength-1:0] s1_addr_q, s1_addr_d;
  logic [pDataLength-1:0] s1_tap_q, s1_tap_d;
  logic                   take_s;
  logic [pAddrLength-1:0] take_addr_s;
  logic [pAddrLength-1:0] term_addr_s;

  // Drain stream.
  logic [pAddrLength-1:0] rd_ptr_q, rd_ptr_d;
  logic                   rd_all_q, rd_all_d;
  logic                   rd_pend_q, rd_pend_d;
  logic [pAddrLength-1:0] rd_pend_addr_q, rd_pend_addr_d;
  logic                   skid_valid_q, skid_valid_d;
  logic [pAddrLength-1:0] skid_addr_q, skid_addr_d;
  logic [pAccLength-1:0]  skid_val_q, skid_val_d;
  logic                   out_valid_q, out_valid_d;
  logic [pAddrLength-1:0] out_addr_q, out_addr_d;
  logic [pAccLength-1:0]  out_val_q, out_val_d;
  logic                   out_last_q, out_last_d;
  logic                   pop_s;
  logic                   out_free_s;
  logic                   issue_s;
  logic [1:0]             occ_s;
  logic [1:0]             occ_after_s;

  // RAM ports and adder.
  logic                   ram_we_s;
  logic [pAddrLength-1:0] ram_waddr_s;
  logic [pAccLength-1:0]  ram_wdata_s;
  logic                   ram_re_s;
  logic [pAddrLength-1:0] ram_raddr_s;
  logic [pAccLength-1:0]  ram_rdata_s;
  logic [kSumW-1:0]       tap_ext_s;
  logic [kSumW-1:0]       acc_ext_s;
  logic [kSumW-1:0]       sum_s;
  logic                   ovf_s;
  logic [pAccLength-1:0]  sat_sum_s;

  // Saturating add of the stage-1 tap onto the accumulator just read.
  always_comb begin
    tap_ext_s = {{(kSumW-pDataLength){s1_tap_q[pDataLength-1]}}, s1_tap_q};
    acc_ext_s = {{kSatGuardBits{ram_rdata_s[pAccLength-1]}}, ram_rdata_s};
    sum_s     = acc_ext_s + tap_ext_s;
    ovf_s     = (sum_s[kSumW-1] != sum_s[pAccLength-1]);
    if (!ovf_s) begin
      sat_sum_s = sum_s[pAccLength-1:0];
    end else if (sum_s[kSumW-1]) begin
      sat_sum_s = kAccMin;
    end else begin
      sat_sum_s = kAccMax;
    end
  end

  // Drain stream: read issue with occupancy credit, skid and output register.
  always_comb begin
    pop_s          = out_valid_q & out_ready;
    out_free_s     = ~out_valid_q | pop_s;
    occ_s          = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_pend_q};
    occ_after_s    = occ_s - {1'b0, pop_s};
    issue_s        = 1'b0;
    rd_ptr_d       = rd_ptr_q;
    rd_all_d       = rd_all_q;
    rd_pend_d      = 1'b0;
    rd_pend_addr_d = rd_pend_addr_q;
    skid_valid_d   = skid_valid_q;
    skid_addr_d    = skid_addr_q;
    skid_val_d     = skid_val_q;
    out_valid_d    = out_valid_q;
    out_addr_d     = out_addr_q;
    out_val_d      = out_val_q;
    out_last_d     = out_last_q;
    if (state_q == ST_DRAIN) begin
      // A read may only be issued if its data is sure to find a slot.
      issue_s = ~rd_all_q & (occ_after_s < 2'd2);
      if (issue_s) begin
        rd_pend_d      = 1'b1;
        rd_pend_addr_d = rd_ptr_q;
        rd_ptr_d       = rd_ptr_q + kOneAddr;
        rd_all_d       = (rd_ptr_q == kLastAddr);
      end else begin
        rd_pend_d      = 1'b0;
      end
      if (out_free_s) begin
        if (skid_valid_q) begin
          out_valid_d  = 1'b1;
          out_addr_d   = skid_addr_q;
          out_val_d    = skid_val_q;
          out_last_d   = (skid_addr_q == kLastAddr);
          skid_valid_d = rd_pend_q;
          skid_addr_d  = rd_pend_addr_q;
          skid_val_d   = ram_rdata_s;
        end else if (rd_pend_q) begin
          out_valid_d  = 1'b1;
          out_addr_d   = rd_pend_addr_q;
          out_val_d    = ram_rdata_s;
          out_last_d   = (rd_pend_addr_q == kLastAddr);
        end else begin
          out_valid_d  = 1'b0;
          out_last_d   = 1'b0;
        end
      end else if (rd_pend_q) begin
        // Output stalled: park the arriving word in the (empty) skid slot.
        skid_valid_d = 1'b1;
        skid_addr_d  = rd_pend_addr_q;
        skid_val_d   = ram_rdata_s;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end else begin
      rd_ptr_d     = kZeroAddr;
      rd_all_d     = 1'b0;
      skid_valid_d = 1'b0;
      out_valid_d  = 1'b0;
      out_last_d   = 1'b0;
    end
  end

  // Main FSM: request arbitration, scan pointer and clear sweep.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    ptr_d       = ptr_q;
    term_seen_d = term_seen_q;
    clr_addr_d  = clr_addr_q;
    line_done_d = 1'b0;
    err_set_s   = 1'b0;
    take_s      = 1'b0;
    take_addr_s = ptr_q;
    term_addr_s = dir_q ? kZeroAddr : kLastAddr;
    case (state_q)
      ST_IDLE: begin
        term_seen_d = 1'b0;
        if (flush) begin
          state_d   = ST_DRAIN;
          err_set_s = clear | pe_en;
        end else if (clear) begin
          state_d    = ST_CLEAR;
          clr_addr_d = kZeroAddr;
          err_set_s  = pe_en;
        end else if (pe_en) begin
          // Entry tap is accepted immediately at the scan start address.
          state_d     = ST_ACCUM;
          dir_d       = pe_scan_dir;
          take_s      = 1'b1;
          take_addr_s = pe_scan_dir ? kLastAddr : kZeroAddr;
          if (take_addr_s == (pe_scan_dir ? kZeroAddr : kLastAddr)) begin
            term_seen_d = 1'b1;
          end else begin
            ptr_d = pe_scan_dir ? (kLastAddr - kOneAddr) : kOneAddr;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        err_set_s = clear | flush;
        if (term_seen_q) begin
          // Final write happens this cycle; taps beyond the line are dropped.
          err_set_s   = clear | flush | pe_en;
          state_d     = ST_IDLE;
          term_seen_d = 1'b0;
          line_done_d = 1'b1;
        end else if (pe_en) begin
          take_s      = 1'b1;
          take_addr_s = ptr_q;
          if (ptr_q == term_addr_s) begin
            term_seen_d = 1'b1;
          end else begin
            ptr_d = dir_q ? (ptr_q - kOneAddr) : (ptr_q + kOneAddr);
          end
        end else begin
          ptr_d = ptr_q;
        end
      end
      ST_CLEAR: begin
        err_set_s = pe_en | clear | flush;
        if (clr_addr_q == kLastAddr) begin
          state_d = ST_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + kOneAddr;
        end
      end
      ST_DRAIN: begin
        err_set_s = pe_en | clear | flush;
        if (pop_s && out_last_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    err_d      = err_q | err_set_s;
    sat_d      = sat_q | (s1_valid_q & ovf_s);
    busy_d     = (state_d == ST_CLEAR) | (state_d == ST_DRAIN);
    s1_valid_d = take_s;
    s1_addr_d  = take_addr_s;
    s1_tap_d   = pe_tap;
  end

  // RAM port steering; writes are suppressed while reset is asserted.
  always_comb begin
    ram_re_s    = take_s | issue_s;
    ram_raddr_s = issue_s ? rd_ptr_q : take_addr_s;
    if (state_q == ST_CLEAR) begin
      ram_we_s    = reset_n;
      ram_waddr_s = clr_addr_q;
      ram_wdata_s = '0;
    end else begin
      ram_we_s    = reset_n & s1_valid_q;
      ram_waddr_s = s1_addr_q;
      ram_wdata_s = sat_sum_s;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      dir_q          <= 1'b0;
      ptr_q          <= '0;
      term_seen_q    <= 1'b0;
      clr_addr_q     <= '0;
      busy_q         <= 1'b0;
      line_done_q    <= 1'b0;
      err_q          <= 1'b0;
      sat_q          <= 1'b0;
      s1_valid_q     <= 1'b0;
      s1_addr_q      <= '0;
      s1_tap_q       <= '0;
      rd_ptr_q       <= '0;
      rd_all_q       <= 1'b0;
      rd_pend_q      <= 1'b0;
      rd_pend_addr_q <= '0;
      skid_valid_q   <= 1'b0;
      skid_addr_q    <= '0;
      skid_val_q     <= '0;
      out_valid_q    <= 1'b0;
      out_addr_q     <= '0;
      out_val_q      <= '0;
      out_last_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      dir_q          <= dir_d;
      ptr_q          <= ptr_d;
      term_seen_q    <= term_seen_d;
      clr_addr_q     <= clr_addr_d;
      busy_q         <= busy_d;
      line_done_q    <= line_done_d;
      err_q          <= err_d;
      sat_q          <= sat_d;
      s1_valid_q     <= s1_valid_d;
      s1_addr_q      <= s1_addr_d;
      s1_tap_q       <= s1_tap_d;
      rd_ptr_q       <= rd_ptr_d;
      rd_all_q       <= rd_all_d;
      rd_pend_q      <= rd_pend_d;
      rd_pend_addr_q <= rd_pend_addr_d;
      skid_valid_q   <= skid_valid_d;
      skid_addr_q    <= skid_addr_d;
      skid_val_q     <= skid_val_d;
      out_valid_q    <= out_valid_d;
      out_addr_q     <= out_addr_d;
      out_val_q      <= out_val_d;
      out_last_q     <= out_last_d;
    end
  end

  nabp_pe_line_ram #(
    .pWidth      (pAccLength),
    .pDepth      (pImageSize),
    .pAddrLength (pAddrLength)
  ) u_line_ram (
    .clk     (clk),
    .we_i    (ram_we_s),
    .waddr_i (ram_waddr_s),
    .wdata_i (ram_wdata_s),
    .re_i    (ram_re_s),
    .raddr_i (ram_raddr_s),
    .rdata_o (ram_rdata_s)
  );

  assign pe_busy   = busy_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_val   = out_val_q;
  assign out_last  = out_last_q;
  assign line_done = line_done_q;
  assign err       = err_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_nabp_processing_element.sv
// Self-checking bench for nabp_processing_element: a bench-side accumulator
// model feeds a scoreboard queue that is checked against the drain stream.
module tb_nabp_processing_element;

  localparam int DW      = 18;
  localparam int AW      = 20;
  localparam int N       = 256;
  localparam int ABW     = 8;
  localparam int ACC_MAX = 524287;
  localparam int ACC_MIN = -524288;

  typedef struct packed {
    logic [ABW-1:0] addr;
    logic [AW-1:0]  val;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           pe_en;
  logic [DW-1:0]  pe_tap;
  logic           pe_scan_dir;
  logic           clear;
  logic           flush;
  logic           pe_busy;
  logic           out_valid;
  logic           out_ready;
  logic [ABW-1:0] out_addr;
  logic [AW-1:0]  out_val;
  logic           out_last;
  logic           line_done;
  logic           err;
  logic           sat;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   model [N];
  exp_t sb_q [$];

  always #5 clk = ~clk;

  nabp_processing_element #(
    .pDataLength (DW),
    .pAccLength  (AW),
    .pImageSize  (N),
    .pAddrLength (ABW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pe_en       (pe_en),
    .pe_tap      (pe_tap),
    .pe_scan_dir (pe_scan_dir),
    .clear       (clear),
    .flush       (flush),
    .pe_busy     (pe_busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_val     (out_val),
    .out_last    (out_last),
    .line_done   (line_done),
    .err         (err),
    .sat         (sat)
  );

  function automatic int sat_add(input int a, input int b);
    longint s;
    s = longint'(a) + longint'(b);
    if (s > ACC_MAX) return ACC_MAX;
    if (s < ACC_MIN) return ACC_MIN;
    return int'(s);
  endfunction

  function automatic int tap_for(input int kind, input int val, input int a);
    if (kind == 1) return a;
    if (kind == 2) return (a == 0) ? val : ((a == 1) ? -val : 0);
    return val;
  endfunction

  task automatic test_reset();
    logic [33:0] obs;
    reset_n = 1'b0; pe_en = 1'b1; flush = 1'b1; clear = 1'b0;
    pe_tap = '0; pe_scan_dir = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    obs = {pe_busy, out_valid, out_last, line_done, err, sat, out_addr, out_val};
    n_cmp++;
    if (obs !== 34'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", obs);
    end
    pe_en = 1'b0; flush = 1'b0; reset_n = 1'b1;
    repeat (2) @(negedge clk);
    obs = {pe_busy, out_valid, out_last, line_done, err, sat, out_addr, out_val};
    n_cmp++;
    if (obs !== 34'd0) begin
      n_bad++; $display("FAIL post_reset_idle: got %h want 0", obs);
    end
  endtask

  task automatic do_clear();
    int cnt;
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    n_cmp++;
    if (pe_busy !== 1'b1) begin
      n_bad++; $display("FAIL clear_busy: got %b want 1", pe_busy);
    end
    cnt = 0;
    while (pe_busy === 1'b1 && cnt < 400) begin
      @(negedge clk); cnt++;
    end
    n_cmp++;
    if (cnt != N) begin
      n_bad++; $display("FAIL clear_length: got %0d cycles want %0d", cnt, N);
    end
    for (int k = 0; k < N; k++) model[k] = 0;
  endtask

  task automatic run_line(input bit dir, input int kind, input int val, input bit stall3);
    int n, c, a, tap, pulses;
    n = 0; c = 0; pulses = 0;
    while (n < N) begin
      @(negedge clk);
      if (line_done === 1'b1) pulses++;
      a = dir ? (N - 1 - n) : n;
      // direction must be latched at entry: flip it afterwards
      pe_scan_dir = (n == 0) ? dir : !dir;
      if (stall3 && (c % 3 == 2)) begin
        pe_en = 1'b0; pe_tap = DW'(999);
      end else begin
        tap = tap_for(kind, val, a);
        pe_en = 1'b1; pe_tap = DW'(tap);
        model[a] = sat_add(model[a], tap);
        n++;
      end
      c++;
    end
    @(negedge clk); pe_en = 1'b0;
    if (line_done === 1'b1) pulses++;
    repeat (6) begin
      @(negedge clk);
      if (line_done === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 1) begin
      n_bad++; $display("FAIL line_done_pulses: got %0d want 1", pulses);
    end
  endtask

  // mode 0: out_ready held 1; mode 1: out_ready pattern 1,0,0,1
  task automatic do_drain(input int mode, input bit inject_en, input bit also_clear);
    int cyc, got;
    bit done, rdy, stalled;
    logic [ABW-1:0] s_addr;
    logic [AW-1:0]  s_val;
    logic           s_last;
    exp_t e;
    bit pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int k = 0; k < N; k++) begin
      e.addr = ABW'(k); e.val = AW'(model[k]);
      sb_q.push_back(e);
    end
    @(negedge clk); flush = 1'b1; clear = also_clear; out_ready = 1'b1;
    @(negedge clk); flush = 1'b0; clear = 1'b0;
    cyc = 0; got = 0; done = 1'b0; stalled = 1'b0;
    s_addr = '0; s_val = '0; s_last = 1'b0;
    while (!done && cyc < 2000) begin
      if (stalled) begin
        n_cmp++;
        if ({out_valid, out_addr, out_val, out_last} !== {1'b1, s_addr, s_val, s_last}) begin
          n_bad++;
          $display("FAIL stall_stable: got v%b a%0d d%h l%b want v1 a%0d d%h l%b",
                   out_valid, out_addr, out_val, out_last, s_addr, s_val, s_last);
        end
      end
      rdy = (mode == 0) ? 1'b1 : pat[cyc % 4];
      out_ready = rdy;
      pe_en = inject_en && (cyc % 5 == 1);
      pe_tap = DW'(7);
      if (out_valid === 1'b1 && rdy) begin
        got++;
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL drain_extra: got addr %0d want none", out_addr);
        end else begin
          e = sb_q.pop_front();
          n_cmp++;
          if (out_addr !== e.addr || out_val !== e.val) begin
            n_bad++;
            $display("FAIL drain_word: got a%0d d%h want a%0d d%h", out_addr, out_val, e.addr, e.val);
          end
          n_cmp++;
          if (out_last !== (e.addr == ABW'(N - 1))) begin
            n_bad++;
            $display("FAIL drain_last: got %b at a%0d want %b", out_last, e.addr, (e.addr == ABW'(N - 1)));
          end
        end
        if (out_last === 1'b1) done = 1'b1;
      end
      stalled = (out_valid === 1'b1) && !rdy;
      s_addr = out_addr; s_val = out_val; s_last = out_last;
      @(negedge clk); cyc++;
    end
    pe_en = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (!done || got != N || sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_complete: got %0d words done=%b left=%0d want %0d words", got, done, sb_q.size(), N);
    end
    sb_q.delete();
    n_cmp++;
    if (out_valid !== 1'b0 || pe_busy !== 1'b0) begin
      n_bad++; $display("FAIL drain_exit: got valid %b busy %b want 0 0", out_valid, pe_busy);
    end
    if (mode == 0) begin
      n_cmp++;
      if (cyc > N + 4) begin
        n_bad++; $display("FAIL drain_rate: got %0d cycles want <= %0d", cyc, N + 4);
      end
    end
  endtask

  task automatic test_ascending_const();
    do_clear();
    run_line(1'b0, 0, 5, 1'b0);
    do_drain(0, 1'b0, 1'b0);
    n_cmp++;
    if (err !== 1'b0 || sat !== 1'b0) begin
      n_bad++; $display("FAIL flags_clean: got err %b sat %b want 0 0", err, sat);
    end
  endtask

  task automatic test_descending_stall();
    do_clear();
    run_line(1'b1, 1, 0, 1'b1);
    do_drain(0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    do_clear();
    for (int l = 0; l < 6; l++) begin
      run_line(l[0], 2, 100000, 1'b0);
      if (l == 4) begin
        n_cmp++;
        if (sat !== 1'b0) begin
          n_bad++; $display("FAIL sat_early: got %b want 0", sat);
        end
      end
    end
    n_cmp++;
    if (sat !== 1'b1) begin
      n_bad++; $display("FAIL sat_set: got %b want 1", sat);
    end
    do_drain(0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back_backpressure();
    run_line(1'b0, 1, 0, 1'b0);
    run_line(1'b1, 0, -3, 1'b0);
    do_drain(1, 1'b0, 1'b0);
  endtask

  task automatic test_conflicts();
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++; $display("FAIL err_before: got %b want 0", err);
    end
    do_drain(0, 1'b1, 1'b1);
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++; $display("FAIL err_conflict: got %b want 1", err);
    end
    do_drain(1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_accum();
    logic [33:0] obs;
    do_clear();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); pe_en = 1'b1; pe_tap = DW'(1); pe_scan_dir = 1'b0;
    end
    @(negedge clk); reset_n = 1'b0; pe_en = 1'b1;
    @(negedge clk); reset_n = 1'b1; pe_en = 1'b0;
    obs = {pe_busy, out_valid, out_last, line_done, err, sat, out_addr, out_val};
    n_cmp++;
    if (obs !== 34'd0) begin
      n_bad++; $display("FAIL mid_reset_outputs: got %h want 0", obs);
    end
    do_clear();
    run_line(1'b1, 0, 3, 1'b0);
    do_drain(0, 1'b0, 1'b0);
  endtask

  initial begin
    #(5000000);
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) model[k] = 0;
    test_reset();
    test_ascending_const();
    test_descending_stall();
    test_saturation();
    test_back_to_back_backpressure();
    test_conflicts();
    test_reset_mid_accum();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
